div_sequencer: RTL

- Multi-cycle signed 32-bit integer divider controller for the ALU division path.
- Latches operands on a start request, runs a radix-2 restoring shift/subtract loop (one quotient bit per clock), applies sign correction, and presents a result as {remainder, quotient}.
- The result packing is the same as the combinational divider, so it writes directly into the HI/LO registers.
- Replaces the long combinational path so the datapath can run at the target clock, at the cost of a fixed multi-cycle latency.

---
 rtl/div_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed divider controller for the ALU division path.
// Radix-2 restoring loop, one quotient bit per clock, sign fix-up at the end.
// result = {remainder, quotient}, matching the combinational divider packing.
module div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DW_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ITERATE = 3'd2,
    FIXUP   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Two's complement negate, wrapping at DATA_WIDTH (so -(2^(W-1)) stays put).
  function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
    return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t                    state_r, state_s;
  logic [DATA_WIDTH-1:0]     dvd_r, dvs_r, dvs_mag_r, rem_r, quo_r;
  logic [CW-1:0]             cnt_r;
  logic                      sign_q_r, sign_r_r;
  logic                      busy_r, done_r, dbz_r;
  logic [2*DATA_WIDTH-1:0]   result_r;
  logic [DATA_WIDTH:0]       shift_s, diff_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign result      = result_r;

  // State register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (dvs_r == DW_ZERO) begin
          state_s = DONE;
        end else begin
          state_s = ITERATE;
        end
      end
      ITERATE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = FIXUP;
        end else begin
          state_s = ITERATE;
        end
      end
      FIXUP:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Trial subtraction: shift one dividend bit into the partial remainder, subtract |divisor|.
  always_comb begin
    shift_s = {rem_r, quo_r[DATA_WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvs_mag_r};
  end

  // Datapath and registered outputs; result only moves on the way into DONE.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      dvd_r     <= DW_ZERO;
      dvs_r     <= DW_ZERO;
      dvs_mag_r <= DW_ZERO;
      rem_r     <= DW_ZERO;
      quo_r     <= DW_ZERO;
      cnt_r     <= CNT_ZERO;
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      dbz_r     <= 1'b0;
      result_r  <= {(2*DATA_WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            dbz_r <= 1'b0;
          end
        end
        SETUP: begin
          sign_q_r  <= dvd_r[DATA_WIDTH-1] ^ dvs_r[DATA_WIDTH-1];
          sign_r_r  <= dvd_r[DATA_WIDTH-1];
          quo_r     <= dvd_r[DATA_WIDTH-1] ? twos_neg(dvd_r) : dvd_r;
          dvs_mag_r <= dvs_r[DATA_WIDTH-1] ? twos_neg(dvs_r) : dvs_r;
          rem_r     <= DW_ZERO;
          cnt_r     <= CNT_LAST;
          if (dvs_r == DW_ZERO) begin
            // Zero divisor: report the raw dividend as remainder, quotient 0.
            result_r <= {dvd_r, DW_ZERO};
            dbz_r    <= 1'b1;
          end
        end
        ITERATE: begin
          rem_r <= diff_s[DATA_WIDTH] ? shift_s[DATA_WIDTH-1:0] : diff_s[DATA_WIDTH-1:0];
          quo_r <= {quo_r[DATA_WIDTH-2:0], ~diff_s[DATA_WIDTH]};
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        FIXUP: begin
          result_r <= {(sign_r_r ? twos_neg(rem_r) : rem_r),
                       (sign_q_r ? twos_neg(quo_r) : quo_r)};
        end
        default: begin
        end
      endcase
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

endmodule
